pe_nic: RTL and testbench

Network interface controller between a processing element and the PE port of a ring router. It holds one inbound and one outbound packet register, and exposes them with their status flags through a 2-bit-addressed register interface. It injects outbound packets into the router only on the polarity that matches the packet's virtual-channel bit, and accepts inbound packets whenever its input register is empty.

---
 rtl/ring_pkg.sv | 31 +++
 rtl/nic_channel_reg.sv | 43 ++++
 rtl/pe_nic.sv | 86 ++++++++
 tb/tb_pe_nic.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared ring-network definitions: packet geometry, header fields, NIC register map.
package ring_pkg;

  localparam int unsigned PACKET_SIZE = 64;
  localparam int unsigned VC_BIT      = 63;
  localparam int unsigned DIR_BIT     = 62;
  localparam int unsigned HOP_MSB     = 55;
  localparam int unsigned HOP_LSB     = 48;

  typedef logic [PACKET_SIZE-1:0] packet_t;

  // PE-visible NIC register map
  localparam logic [1:0] ADDR_IN_BUF   = 2'd0;
  localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'd2;
  localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

  // Virtual-channel bit of a packet header
  function automatic logic pkt_vc(input packet_t pkt);
    return pkt[VC_BIT];
  endfunction

  // Status word carrying a single flag in bit 0
  function automatic packet_t status_word(input logic flag);
    packet_t w;
    w    = '0;
    w[0] = flag;
    return w;
  endfunction

endpackage

// File: rtl/nic_channel_reg.sv
// One packet register plus full flag; load fills it, clear empties it.
module nic_channel_reg
  import ring_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load_i,
  input  logic    clear_i,
  input  packet_t data_i,
  output packet_t data_o,
  output logic    full_o
);

  packet_t data_q, data_d;
  logic    full_q, full_d;

  // Next state: load and clear are never requested together by the NIC glue
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (clear_i) begin
      full_d = 1'b0;
    end
  end

  // Synchronous active-high reset discards any buffered packet
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/pe_nic.sv
// PE-side network interface: one inbound and one outbound packet register,
// register-mapped to the PE, with polarity-gated injection into the ring router.
module pe_nic
  import ring_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             addr,
  input  logic [PACKET_SIZE-1:0] d_in,
  output logic [PACKET_SIZE-1:0] d_out,
  input  logic                   nicEn,
  input  logic                   nicWrEn,
  output logic                   net_so,
  input  logic                   net_ro,
  output logic [PACKET_SIZE-1:0] net_do,
  input  logic                   net_polarity,
  input  logic                   net_si,
  output logic                   net_ri,
  input  logic [PACKET_SIZE-1:0] net_di
);

  packet_t in_buf, out_buf;
  logic    in_full, out_full;
  logic    pe_rd, pe_wr;
  logic    in_load, in_clear, out_load, out_clear;
  packet_t d_out_q, d_out_d;

  assign pe_rd = nicEn & ~nicWrEn;
  assign pe_wr = nicEn & nicWrEn;

  // Inbound: accept only when empty; an addr-0 read drains it
  assign net_ri   = ~in_full;
  assign in_load  = net_si & ~in_full;
  assign in_clear = pe_rd & (addr == ADDR_IN_BUF) & in_full;

  // Outbound: writes to a full register are dropped; the send empties it
  assign out_load  = pe_wr & (addr == ADDR_OUT_BUF) & ~out_full;
  assign net_so    = out_full & net_ro & (pkt_vc(out_buf) == net_polarity);
  assign out_clear = net_so;
  assign net_do    = out_buf;

  nic_channel_reg u_in_chan (
    .clk     (clk),
    .reset   (reset),
    .load_i  (in_load),
    .clear_i (in_clear),
    .data_i  (net_di),
    .data_o  (in_buf),
    .full_o  (in_full)
  );

  nic_channel_reg u_out_chan (
    .clk     (clk),
    .reset   (reset),
    .load_i  (out_load),
    .clear_i (out_clear),
    .data_i  (d_in),
    .data_o  (out_buf),
    .full_o  (out_full)
  );

  // Read mux: d_out only changes on a PE read, otherwise holds
  always_comb begin
    d_out_d = d_out_q;
    if (pe_rd) begin
      case (addr)
        ADDR_IN_BUF:   d_out_d = in_buf;
        ADDR_IN_STAT:  d_out_d = status_word(in_full);
        ADDR_OUT_STAT: d_out_d = status_word(out_full);
        default:       d_out_d = '0;
      endcase
    end
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_pe_nic.sv
// Directed bench for pe_nic with a behavioural NIC model checked every cycle.
module tb_pe_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_polarity = 1'b0;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [63:0] net_di = '0;

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;

  // Behavioural model state
  logic [63:0] m_in_buf = '0;
  logic        m_in_full = 1'b0;
  logic [63:0] m_out_buf = '0;
  logic        m_out_full = 1'b0;
  logic [63:0] m_d_out = '0;
  logic [63:0] sent_q[$];

  pe_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_send();
    return m_out_full && net_ro && (m_out_buf[63] == net_polarity);
  endfunction

  // Model update from the register-level rules, plus capture of sent packets
  always @(posedge clk) begin
    if (reset) begin
      m_in_buf   <= '0;
      m_in_full  <= 1'b0;
      m_out_buf  <= '0;
      m_out_full <= 1'b0;
      m_d_out    <= '0;
    end else begin
      if (net_si && !m_in_full) begin
        m_in_buf  <= net_di;
        m_in_full <= 1'b1;
      end
      if (nicEn && !nicWrEn) begin
        if (addr == 2'd0) begin
          m_d_out <= m_in_buf;
          if (m_in_full) m_in_full <= 1'b0;
        end else if (addr == 2'd1) m_d_out <= {63'd0, m_in_full};
        else if (addr == 2'd3) m_d_out <= {63'd0, m_out_full};
        else m_d_out <= '0;
      end
      if (nicEn && nicWrEn && addr == 2'd2 && !m_out_full) begin
        m_out_buf  <= d_in;
        m_out_full <= 1'b1;
      end
      if (model_send()) m_out_full <= 1'b0;
      if (net_so) begin
        sent_q.push_back(net_do);
        check("so_polarity", {63'd0, net_polarity}, {63'd0, net_do[63]});
      end
    end
  end

  // Per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (armed) begin
      check("cyc_net_ri", {63'd0, net_ri}, {63'd0, ~m_in_full});
      check("cyc_net_so", {63'd0, net_so}, {63'd0, model_send()});
      check("cyc_net_do", net_do, m_out_buf);
      check("cyc_d_out", d_out, m_d_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    net_polarity = ~net_polarity;
  endtask

  task automatic rd(input logic [1:0] a, input logic [63:0] exp, input string nm);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    step();
    nicEn = 1'b0;
    check(nm, d_out, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
    step();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic wait_send(input int n0, input int max_cyc, input string nm);
    for (int i = 0; i < max_cyc; i++) begin
      if (sent_q.size() > n0) break;
      step();
    end
    check(nm, 64'(sent_q.size()), 64'(n0 + 1));
  endtask

  initial begin
    int n;
    logic [63:0] pkt;

    // 1. Reset
    reset = 1'b1;
    step();
    armed = 1'b1;
    step();
    reset = 1'b0;
    check("rst_net_so", {63'd0, net_so}, 64'd0);
    check("rst_net_ri", {63'd0, net_ri}, 64'd1);
    check("rst_d_out", d_out, 64'd0);
    rd(2'd1, 64'd0, "rst_in_stat");
    rd(2'd3, 64'd0, "rst_out_stat");

    // 2. Receive path
    net_si = 1'b1; net_di = 64'h0000_0000_0000_ABCD;
    step();
    net_si = 1'b0;
    check("rx_net_ri_low", {63'd0, net_ri}, 64'd0);
    rd(2'd1, 64'd1, "rx_in_stat_full");
    rd(2'd0, 64'h0000_0000_0000_ABCD, "rx_in_buf");
    check("rx_net_ri_back", {63'd0, net_ri}, 64'd1);
    rd(2'd1, 64'd0, "rx_in_stat_empty");
    rd(2'd0, 64'h0000_0000_0000_ABCD, "rx_stale_read");
    rd(2'd2, 64'd0, "rd_out_buf_zero");

    // 3. Polarity gating
    net_ro = 1'b1;
    n = sent_q.size();
    wr(2'd2, 64'h8000_0000_0000_0001);
    wait_send(n, 3, "pol_send_count");
    for (int i = 0; i < 3; i++) step();
    check("pol_send_once", 64'(sent_q.size()), 64'(n + 1));
    check("pol_pkt", sent_q[sent_q.size()-1], 64'h8000_0000_0000_0001);
    rd(2'd3, 64'd0, "pol_out_stat");

    // 4. Backpressure
    net_ro = 1'b0;
    wr(2'd2, 64'h0000_0000_0000_0005);
    for (int i = 0; i < 10; i++) begin
      check("bp_so_low", {63'd0, net_so}, 64'd0);
      step();
    end
    rd(2'd3, 64'd1, "bp_out_full");
    n = sent_q.size();
    net_ro = 1'b1;
    wait_send(n, 2, "bp_send_within_2");
    check("bp_pkt", sent_q[sent_q.size()-1], 64'h0000_0000_0000_0005);

    // 5. Dropped write
    net_ro = 1'b0;
    wr(2'd2, 64'h0000_0000_0000_1111);
    wr(2'd2, 64'h0000_0000_0000_2222);
    check("drop_net_do", net_do, 64'h0000_0000_0000_1111);
    n = sent_q.size();
    net_ro = 1'b1;
    wait_send(n, 3, "drop_send");
    for (int i = 0; i < 4; i++) step();
    check("drop_one_pkt", 64'(sent_q.size()), 64'(n + 1));
    check("drop_pkt", sent_q[sent_q.size()-1], 64'h0000_0000_0000_1111);

    // 6. Concurrent receive + send, then reset with a pending packet
    net_ro = 1'b0;
    pkt = 64'h0000_0000_0000_7777;
    pkt[63] = ~net_polarity;  // matches polarity in the cycle after the write
    wr(2'd2, pkt);
    n = sent_q.size();
    net_ro = 1'b1; net_si = 1'b1; net_di = 64'h0000_0000_0000_BEEF;
    step();
    net_si = 1'b0; net_ro = 1'b0;
    check("cc_send", 64'(sent_q.size()), 64'(n + 1));
    check("cc_pkt", sent_q[sent_q.size()-1], pkt);
    check("cc_net_ri", {63'd0, net_ri}, 64'd0);
    rd(2'd0, 64'h0000_0000_0000_BEEF, "cc_rx");

    wr(2'd2, 64'h0000_0000_0000_3333);
    rd(2'd3, 64'd1, "rst_pending_full");
    n = sent_q.size();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_net_so", {63'd0, net_so}, 64'd0);
    check("rst2_net_ri", {63'd0, net_ri}, 64'd1);
    rd(2'd3, 64'd0, "rst2_out_stat");
    net_ro = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rst2_no_send", 64'(sent_q.size()), 64'(n));

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
